// File: rtl/stack_ctrl_pkg.sv
// Package for the stack controller: local helpers derived from DEPTH.
`ifndef WIDTH
`define WIDTH 16
`endif

package stack_ctrl_pkg;

  // Request decoded from the push/pop pair.
  typedef enum logic [1:0] {
    OP_IDLE    = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_e;

  // Capacity is the register file plus the tos register.
  function automatic int unsigned capacity(input int unsigned depth);
    return (1 << depth) + 1;
  endfunction

endpackage

// File: rtl/stack_ctrl_if.sv
// Request/response bundle between a stack user (master) and stack_ctrl (slave).
// Handshake: there is no valid/ready pair; push/pop are single-cycle requests
// sampled on every rising clk, refused requests only raise a sticky flag, and
// every result is visible on the outputs one cycle after the request edge.
interface stack_ctrl_if #(
  parameter int DEPTH = 4
);
  logic              push;
  logic              pop;
  logic [`WIDTH-1:0] din;
  logic              clr_err;
  logic [`WIDTH-1:0] tos;
  logic [`WIDTH-1:0] nos;
  logic [DEPTH:0]    count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, pop, din, clr_err,
    input  tos, nos, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, din, clr_err,
    output tos, nos, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/common.sv
// Shared codebase constants. Guarded so it can be pulled in more than once.
`ifndef COMMON_V
`define COMMON_V
`define WIDTH 16
`endif

// File: rtl/stack_ctrl_stack.sv
// Backing register file: 2**DEPTH entries, one synchronous write port and
// one combinational read port. Contents are deliberately not reset.
module stack_ctrl_stack #(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [DEPTH-1:0]  wa,
  input  logic [`WIDTH-1:0] wd,
  input  logic [DEPTH-1:0]  ra,
  output logic [`WIDTH-1:0] rd
);
  logic [`WIDTH-1:0] mem [0:(1<<DEPTH)-1];

  // Write port: store wd at wa when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  assign rd = mem[ra];
endmodule

// File: rtl/stack_ctrl.sv
// Stack controller: top element held in the tos register, the rest in the
// backing register file at addresses 0..count-2. Sticky overflow/underflow.
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          resetq,
  stack_ctrl_if.slave   bus
);
  localparam int unsigned CAP = capacity(DEPTH);
  localparam logic [DEPTH:0] CAP_C = CAP[DEPTH:0];

  logic [`WIDTH-1:0] tos_q;
  logic [DEPTH:0]    count_q;
  logic              ovf_q;
  logic              unf_q;

  logic              is_empty;
  logic              is_full;
  logic              we;
  logic [DEPTH-1:0]  wa;
  logic [DEPTH-1:0]  ra;
  logic [`WIDTH-1:0] rd;
  logic [DEPTH:0]    cnt_m1;
  logic [DEPTH:0]    cnt_m2;
  stack_op_e         op;

  assign op       = stack_op_e'({bus.push, bus.pop});
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CAP_C);

  // sp = count-1 is the next free slot; the memory top is at sp-1 = count-2.
  // Guards keep both in range: writes need count<=2**DEPTH, reads count>=2.
  assign cnt_m1 = count_q - 1'b1;
  assign cnt_m2 = count_q - 2'd2;
  assign wa     = cnt_m1[DEPTH-1:0];
  assign ra     = cnt_m2[DEPTH-1:0];

  // Memory write only for a plain push onto a non-empty, non-full stack.
  always_comb begin
    we = 1'b0;
    if (!resetq && op == OP_PUSH && !is_empty && !is_full) we = 1'b1;
  end

  stack_ctrl_stack #(.DEPTH(DEPTH)) u_stack (
    .clk (clk),
    .we  (we),
    .wa  (wa),
    .wd  (tos_q),
    .ra  (ra),
    .rd  (rd)
  );

  // Control: tos/count update per request, flags sticky with error-wins clear.
  always_ff @(posedge clk or posedge resetq) begin
    if (resetq) begin
      tos_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (bus.clr_err) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end
      case (op)
        OP_PUSH: begin
          if (is_full) begin
            ovf_q <= 1'b1;
          end else begin
            tos_q   <= bus.din;
            count_q <= count_q + 1'b1;
          end
        end
        OP_POP: begin
          if (is_empty) begin
            unf_q <= 1'b1;
          end else if (count_q == 1) begin
            tos_q   <= '0;
            count_q <= '0;
          end else begin
            tos_q   <= rd;
            count_q <= cnt_m1;
          end
        end
        OP_REPLACE: begin
          if (is_empty) unf_q <= 1'b1;
          else          tos_q <= bus.din;
        end
        default: ;
      endcase
    end
  end

  assign bus.tos       = tos_q;
  assign bus.nos       = (count_q < 2) ? '0 : rd;
  assign bus.count     = count_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl (DEPTH=4, capacity 17).
module tb_stack_ctrl;
  localparam int DEPTH = 4;
  localparam int W = `WIDTH;

  logic clk;
  logic resetq;

  stack_ctrl_if #(.DEPTH(DEPTH)) bus ();

  stack_ctrl #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetq (resetq),
    .bus    (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  typedef struct {
    logic         push;
    logic         pop;
    logic         clr;
    logic [W-1:0] din;
    logic [W-1:0] tos;
    logic [W-1:0] nos;
    int           count;
    logic         empty;
    logic         full;
    logic         ovf;
    logic         unf;
  } vec_t;

  vec_t vecs [0:17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] tos, input logic [W-1:0] nos,
                           input int count, input logic empty, input logic full,
                           input logic ovf, input logic unf);
    check({tag, ".tos"},   32'(bus.tos), 32'(tos));
    check({tag, ".nos"},   32'(bus.nos), 32'(nos));
    check({tag, ".count"}, 32'(bus.count), count[31:0]);
    check({tag, ".empty"}, 32'(bus.empty), 32'(empty));
    check({tag, ".full"},  32'(bus.full), 32'(full));
    check({tag, ".ovf"},   32'(bus.overflow), 32'(ovf));
    check({tag, ".unf"},   32'(bus.underflow), 32'(unf));
  endtask

  // Driver: set inputs on the falling edge, clock once, sample #1 later.
  task automatic apply(input logic push, input logic pop, input logic clr, input logic [W-1:0] din);
    @(negedge clk);
    bus.push = push; bus.pop = pop; bus.clr_err = clr; bus.din = din;
    @(posedge clk);
    #1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.clr_err = 1'b0;
  endtask

  function automatic vec_t mk(input logic pu, input logic po, input logic cl, input logic [W-1:0] d,
                              input logic [W-1:0] t, input logic [W-1:0] n, input int c,
                              input logic e, input logic ov, input logic un);
    vec_t v;
    v.push = pu; v.pop = po; v.clr = cl; v.din = d;
    v.tos = t; v.nos = n; v.count = c; v.empty = e; v.full = 1'b0; v.ovf = ov; v.unf = un;
    return v;
  endfunction

  initial begin
    checks = 0;
    failures = 0;
    bus.push = 1'b0; bus.pop = 1'b0; bus.clr_err = 1'b0; bus.din = '0;

    //            push pop clr din     tos     nos     cnt empty ovf unf
    vecs[0]  = mk(1, 0, 0, 16'h11, 16'h11, 16'h00, 1, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 16'h22, 16'h22, 16'h11, 2, 0, 0, 0);
    vecs[2]  = mk(1, 0, 0, 16'h33, 16'h33, 16'h22, 3, 0, 0, 0);
    vecs[3]  = mk(0, 1, 0, 16'h00, 16'h22, 16'h11, 2, 0, 0, 0);
    vecs[4]  = mk(0, 1, 0, 16'h00, 16'h11, 16'h00, 1, 0, 0, 0);
    vecs[5]  = mk(0, 1, 0, 16'h00, 16'h00, 16'h00, 0, 1, 0, 0);
    vecs[6]  = mk(0, 1, 0, 16'h00, 16'h00, 16'h00, 0, 1, 0, 1);
    vecs[7]  = mk(0, 0, 1, 16'h00, 16'h00, 16'h00, 0, 1, 0, 0);
    vecs[8]  = mk(0, 1, 1, 16'h00, 16'h00, 16'h00, 0, 1, 0, 1);
    vecs[9]  = mk(0, 0, 1, 16'h00, 16'h00, 16'h00, 0, 1, 0, 0);
    vecs[10] = mk(1, 1, 0, 16'h44, 16'h00, 16'h00, 0, 1, 0, 1);
    vecs[11] = mk(0, 0, 1, 16'h00, 16'h00, 16'h00, 0, 1, 0, 0);
    vecs[12] = mk(1, 0, 0, 16'h0B, 16'h0B, 16'h00, 1, 0, 0, 0);
    vecs[13] = mk(1, 0, 0, 16'h0A, 16'h0A, 16'h0B, 2, 0, 0, 0);
    vecs[14] = mk(1, 1, 0, 16'h0C, 16'h0C, 16'h0B, 2, 0, 0, 0);
    vecs[15] = mk(0, 0, 0, 16'h55, 16'h0C, 16'h0B, 2, 0, 0, 0);
    vecs[16] = mk(0, 1, 0, 16'h00, 16'h0B, 16'h00, 1, 0, 0, 0);
    vecs[17] = mk(0, 1, 0, 16'h00, 16'h00, 16'h00, 0, 1, 0, 0);

    // Reset state
    resetq = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 16'h0, 16'h0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("reset.we", 32'(dut.we), 32'd0);
    @(negedge clk);
    resetq = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 18; i++) begin
      apply(vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].din);
      check_all($sformatf("vec%0d", i), vecs[i].tos, vecs[i].nos, vecs[i].count,
                vecs[i].empty, vecs[i].full, vecs[i].ovf, vecs[i].unf);
    end

    // Fill to capacity with 1..17
    for (int k = 1; k <= 17; k++) begin
      apply(1'b1, 1'b0, 1'b0, W'(k));
      check($sformatf("fill%0d.tos", k), 32'(bus.tos), k);
      check($sformatf("fill%0d.count", k), 32'(bus.count), k);
    end
    check_all("full", 16'd17, 16'd16, 17, 1'b0, 1'b1, 1'b0, 1'b0);

    // Push refused at full, then again with clr_err (error wins)
    apply(1'b1, 1'b0, 1'b0, 16'h99);
    check_all("ovf", 16'd17, 16'd16, 17, 1'b0, 1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 16'h99);
    check_all("ovf_clr_win", 16'd17, 16'd16, 17, 1'b0, 1'b1, 1'b1, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 16'h0);
    check("ovf_cleared", 32'(bus.overflow), 32'd0);

    // Drain: 16..1 on tos, then 0
    for (int k = 16; k >= 0; k--) begin
      apply(1'b0, 1'b1, 1'b0, 16'h0);
      check($sformatf("drain%0d.tos", k), 32'(bus.tos), k);
      check($sformatf("drain%0d.count", k), 32'(bus.count), k);
    end
    check_all("drained", 16'h0, 16'h0, 0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a push with count=5
    for (int k = 1; k <= 5; k++) apply(1'b1, 1'b0, 1'b0, W'(16'h20 + k));
    check("pre_rst.count", 32'(bus.count), 32'd5);
    @(negedge clk);
    bus.push = 1'b1; bus.din = 16'h66;
    #1;
    check("pre_rst.we", 32'(dut.we), 32'd1);
    #1;
    resetq = 1'b1;
    #1;
    check_all("async_rst", 16'h0, 16'h0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("async_rst.we", 32'(dut.we), 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold.count", 32'(bus.count), 32'd0);
    @(negedge clk);
    bus.push = 1'b0;
    resetq = 1'b0;
    apply(1'b1, 1'b0, 1'b0, 16'h7);
    check_all("post_rst", 16'h7, 16'h0, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, log2 of the backing register-file entry count (2**DEPTH entries).
REQ-002 SHALL take data width from `WIDTH in common.v, not from a parameter.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock for all state.
REQ-004 resetq  input  1  asynchronous active-high reset (name kept per codebase; polarity is active-high).
REQ-005 push  input  1  push din this cycle.
REQ-006 pop  input  1  pop top of stack this cycle.
REQ-007 din  input  `WIDTH  value to push.
REQ-008 clr_err  input  1  synchronous clear of the sticky error flags.
REQ-009 tos  output  `WIDTH  registered top of stack.
REQ-010 nos  output  `WIDTH  next-on-stack, read combinationally from the backing register file.
REQ-011 count  output  DEPTH+1  number of valid entries, 0..2**DEPTH+1.
REQ-012 empty  output  1  count==0; full  output  1  count==2**DEPTH+1.
REQ-013 overflow  output  1  sticky: push refused; underflow  output  1  sticky: pop refused.

Function
REQ-014 SHALL hold the top element in the tos register and the remaining count-1 elements in an internal stack instance at addresses 0..sp-1, where sp = count-1 if count>0, else 0.
REQ-015 Capacity SHALL be 2**DEPTH+1 elements.
REQ-016 Push only, count==0: tos<=din; count<=1; no memory write.
REQ-017 Push only, 0<count<full: memory[sp]<=tos (we=1, wa=sp, wd=tos); tos<=din; count<=count+1.
REQ-018 Push only, full: no state change except overflow<=1.
REQ-019 Pop only, count>=2: tos<=memory[sp-1] (ra=sp-1); count<=count-1.
REQ-020 Pop only, count==1: count<=0; tos<=0.
REQ-021 Pop only, count==0: no state change except underflow<=1.
REQ-022 Push and pop together, count>=1: replace, i.e. tos<=din, with count and memory unchanged.
REQ-023 Push and pop together, count==0: no state change except underflow<=1.
REQ-024 Neither push nor pop: hold all state; we=0.
REQ-025 All results SHALL be visible on tos/count/flags the cycle after the request edge (latency 1); nos SHALL track the current sp combinationally.
REQ-026 nos SHALL read 0 when count<2.
REQ-027 The memory write enable SHALL be asserted only in REQ-017.
REQ-028 clr_err SHALL clear both flags; an error raised in the same cycle SHALL win, so the flag stays 1.
REQ-029 Address arithmetic SHALL be DEPTH bits wide and SHALL never wrap, because full/empty guards prevent it.

Reset
REQ-030 Asynchronous resetq=1 SHALL immediately force tos=0, count=0, empty=1, full=0, overflow=0, underflow=0, and SHALL deassert the memory write enable.
REQ-031 Reset mid-operation SHALL discard the stack content logically (count=0); the memory array SHALL not be cleared.
REQ-032 The first request SHALL be honoured on the first rising clk after resetq falls.

Structure
REQ-033 `WIDTH SHALL come from the shared common.v.
REQ-034 No new shared constants; capacity SHALL be derived locally from DEPTH.
REQ-035 SHALL instantiate exactly one sub-module, the existing stack register file (DEPTH passed through), as backing store.
REQ-036 Control SHALL be a single registered block, with no additional FSM beyond count/tos.

Verification
REQ-037 Reset, push 0x11, 0x22, 0x33 -> tos=0x33, nos=0x22, count=3, empty=0.
REQ-038 From REQ-037, pop, pop, pop -> tos 0x22, 0x11, then 0; count 2, 1, 0; empty=1; underflow=0.
REQ-039 DEPTH=4: 17 pushes of 1..17 -> full=1, tos=17; an 18th push of 0x99 -> overflow=1, tos=17, count=17; 17 pops return 16..1 on tos in order.
REQ-040 Pop when empty -> underflow=1, count=0; clr_err -> underflow=0; clr_err together with pop on empty -> underflow stays 1.
REQ-041 count=2 (tos=0xA, nos=0xB); push+pop with din=0xC -> tos=0xC, nos=0xB, count=2, no memory write.
REQ-042 Assert resetq asynchronously mid-push with count=5 -> outputs reset without a clock edge; the next push 0x7 gives tos=0x7, count=1.
